// File: rtl/rgb_mixer_pkg.sv
// Shared types and constants for the RGB PWM mixer blocks.
package rgb_mixer_pkg;

    localparam int unsigned LEVEL_W  = 8;
    localparam int unsigned PRESET_W = 3 * LEVEL_W;

    // Channel positions inside a packed {r, g, b} preset word.
    localparam int unsigned R_LSB = 2 * LEVEL_W;
    localparam int unsigned G_LSB = 1 * LEVEL_W;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fade_channel.sv
// One PWM level register: steps one LSB toward a target, or loads a value directly.
module fade_channel
    import rgb_mixer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               step_en,
    input  logic               load_en,
    input  logic [LEVEL_W-1:0] load_val,
    input  logic [LEVEL_W-1:0] target,
    output logic [LEVEL_W-1:0] level,
    output logic               at_target
);

    logic [LEVEL_W:0] level_x;
    logic [LEVEL_W:0] target_x;

    assign level_x  = {1'b0, level};
    assign target_x = {1'b0, target};

    // High when the level equals the target after the next step (already there or one LSB away).
    assign at_target = (level_x == target_x)
                    || ((level_x + (LEVEL_W+1)'(1)) == target_x)
                    || (level_x == (target_x + (LEVEL_W+1)'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else if (load_en) begin
            level <= load_val;
        end else if (step_en) begin
            if (level < target) begin
                level <= level + LEVEL_W'(1);
            end else if (level > target) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps through a preset table, crossfading three PWM levels toward each preset and holding.
module rgb_fade_sequencer
    import rgb_mixer_pkg::*;
#(
    parameter int unsigned NUM_STEPS  = 4,
    parameter int unsigned TICK_DIV   = 256,
    parameter int unsigned HOLD_TICKS = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         manual,
    input  logic [7:0]                   enc0,
    input  logic [7:0]                   enc1,
    input  logic [7:0]                   enc2,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
    input  logic [23:0]                  wr_data,
    output logic [7:0]                   level0,
    output logic [7:0]                   level1,
    output logic [7:0]                   level2,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         busy,
    output logic                         step_done
);

    localparam int unsigned IDX_W  = $clog2(NUM_STEPS);
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [PRESET_W-1:0] preset_tbl [NUM_STEPS];
    logic [PRESET_W-1:0] target;
    logic                tick;
    logic                fade_step;
    logic [2:0]          at_tgt;

    assign target    = preset_tbl[step_idx];
    assign tick      = (state != IDLE) && !manual && (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign fade_step = tick && (state == FADE);

    // Preset table; writes land at the next edge in any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                preset_tbl[i] <= '0;
            end
        end else if (wr_en) begin
            preset_tbl[wr_addr] <= wr_data;
        end
    end

    // Sequencer FSM with prescaler and hold counter; manual freezes everything but the prescaler clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step_idx  <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
        end else begin
            step_done <= 1'b0;
            if (manual) begin
                tick_cnt <= '0;
            end else if (stop) begin
                state    <= IDLE;
                busy     <= 1'b0;
                tick_cnt <= '0;
                hold_cnt <= '0;
            end else if (start) begin
                state    <= FADE;
                busy     <= 1'b1;
                step_idx <= '0;
                tick_cnt <= '0;
                hold_cnt <= '0;
            end else if (state != IDLE) begin
                tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
                if (tick) begin
                    case (state)
                        FADE: begin
                            if (&at_tgt) begin
                                state    <= HOLD;
                                hold_cnt <= '0;
                            end
                        end
                        HOLD: begin
                            if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                                hold_cnt  <= '0;
                                step_done <= 1'b1;
                                step_idx  <= step_idx + IDX_W'(1);
                                state     <= FADE;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    fade_channel u_ch_r (
        .clk       (clk),
        .reset     (reset),
        .step_en   (fade_step),
        .load_en   (manual),
        .load_val  (enc0),
        .target    (target[R_LSB +: LEVEL_W]),
        .level     (level0),
        .at_target (at_tgt[0])
    );

    fade_channel u_ch_g (
        .clk       (clk),
        .reset     (reset),
        .step_en   (fade_step),
        .load_en   (manual),
        .load_val  (enc1),
        .target    (target[G_LSB +: LEVEL_W]),
        .level     (level1),
        .at_target (at_tgt[1])
    );

    fade_channel u_ch_b (
        .clk       (clk),
        .reset     (reset),
        .step_en   (fade_step),
        .load_en   (manual),
        .load_val  (enc2),
        .target    (target[B_LSB +: LEVEL_W]),
        .level     (level2),
        .at_target (at_tgt[2])
    );

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed, table-driven bench for rgb_fade_sequencer with TICK_DIV=4, HOLD_TICKS=2, NUM_STEPS=4.
module tb_rgb_fade_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, manual, wr_en;
    logic [7:0] enc0, enc1, enc2;
    logic [1:0] wr_addr;
    logic [23:0] wr_data;
    logic [7:0] level0, level1, level2;
    logic [1:0] step_idx;
    logic       busy, step_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int r;
        int g;
        int b;
        int idx;
        int done;
    } vec_t;

    vec_t vecs [19];

    rgb_fade_sequencer #(.NUM_STEPS(4), .TICK_DIV(4), .HOLD_TICKS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .manual    (manual),
        .enc0      (enc0),
        .enc1      (enc1),
        .enc2      (enc2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .level0    (level0),
        .level1    (level1),
        .level2    (level2),
        .step_idx  (step_idx),
        .busy      (busy),
        .step_done (step_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_lv(input string name, input int r, input int g, input int b);
        chk({name, ".r"}, int'(level0), r);
        chk({name, ".g"}, int'(level1), g);
        chk({name, ".b"}, int'(level2), b);
    endtask

    task automatic wr(input int addr, input int r, input int g, input int b);
        wr_en   = 1'b1;
        wr_addr = 2'(addr);
        wr_data = {8'(r), 8'(g), 8'(b)};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // tick-by-tick expectations from start: basic fade, step advance, steps 2/3 at zero, wrap
        vecs[0]  = '{1, 1, 0, 0, 0};
        vecs[1]  = '{2, 1, 0, 0, 0};
        vecs[2]  = '{3, 1, 0, 0, 0};
        vecs[3]  = '{3, 1, 0, 0, 0};
        vecs[4]  = '{3, 1, 0, 1, 1};
        vecs[5]  = '{2, 0, 1, 1, 0};
        vecs[6]  = '{1, 0, 2, 1, 0};
        vecs[7]  = '{0, 0, 2, 1, 0};
        vecs[8]  = '{0, 0, 2, 1, 0};
        vecs[9]  = '{0, 0, 2, 2, 1};
        vecs[10] = '{0, 0, 1, 2, 0};
        vecs[11] = '{0, 0, 0, 2, 0};
        vecs[12] = '{0, 0, 0, 2, 0};
        vecs[13] = '{0, 0, 0, 3, 1};
        vecs[14] = '{0, 0, 0, 3, 0};
        vecs[15] = '{0, 0, 0, 3, 0};
        vecs[16] = '{0, 0, 0, 0, 1};
        vecs[17] = '{1, 1, 0, 0, 0};
        vecs[18] = '{2, 1, 0, 0, 0};

        reset = 1'b0; start = 1'b0; stop = 1'b0; manual = 1'b0; wr_en = 1'b0;
        enc0 = 8'd0; enc1 = 8'd0; enc2 = 8'd0; wr_addr = 2'd0; wr_data = 24'd0;
        steps(2);
        reset = 1'b1;
        step();
        chk_lv("reset_lv", 0, 0, 0);
        chk("reset_idx", int'(step_idx), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(step_done), 0);

        wr(0, 3, 1, 0);
        wr(1, 0, 0, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);

        for (int i = 0; i < 19; i++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (c < 3) chk($sformatf("v%0d_done_low", i), int'(step_done), 0);
            end
            chk_lv($sformatf("v%0d", i), vecs[i].r, vecs[i].g, vecs[i].b);
            chk($sformatf("v%0d_idx", i), int'(step_idx), vecs[i].idx);
            chk($sformatf("v%0d_done", i), int'(step_done), vecs[i].done);
            chk($sformatf("v%0d_busy", i), int'(busy), 1);
        end

        // stop mid-fade freezes levels
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        steps(6);
        chk_lv("stop_lv", 2, 1, 0);
        chk("stop_idx", int'(step_idx), 0);
        chk("stop_busy_late", int'(busy), 0);

        // start and stop together from IDLE: stop wins
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("collide_busy", int'(busy), 0);
        steps(5);
        chk("collide_busy_late", int'(busy), 0);
        chk_lv("collide_lv", 2, 1, 0);

        // live rewrite of the active step during fade
        start = 1'b1;
        step();
        start = 1'b0;
        wr(0, 0, 0, 0);
        steps(2);
        chk_lv("rw_pre", 2, 1, 0);
        step();
        chk_lv("rw_t1", 1, 0, 0);
        steps(4);
        chk_lv("rw_t2", 0, 0, 0);
        steps(4);
        chk_lv("rw_t3", 0, 0, 0);
        chk("rw_t3_done", int'(step_done), 0);
        steps(4);
        chk("rw_t4_done", int'(step_done), 1);
        chk("rw_t4_idx", int'(step_idx), 1);

        // manual override during fade toward step1 = (0,0,2)
        enc0 = 8'd200; enc1 = 8'd10; enc2 = 8'd5;
        manual = 1'b1;
        step();
        chk_lv("man_load", 200, 10, 5);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("man_idx", int'(step_idx), 1);
        end
        chk_lv("man_hold", 200, 10, 5);
        chk("man_busy", int'(busy), 1);
        manual = 1'b0;
        steps(3);
        chk_lv("rel_pre", 200, 10, 5);
        step();
        chk_lv("rel_t1", 199, 9, 4);

        // asynchronous reset mid-fade
        #2;
        reset = 1'b0;
        #2;
        chk_lv("arst_lv", 0, 0, 0);
        chk("arst_idx", int'(step_idx), 0);
        chk("arst_busy", int'(busy), 0);
        step();
        reset = 1'b1;
        steps(6);
        chk_lv("post_rst_lv", 0, 0, 0);
        chk("post_rst_busy", int'(busy), 0);

        // table was cleared: steps 0 and 1 both target zero
        start = 1'b1;
        step();
        start = 1'b0;
        steps(12);
        chk("clr_done", int'(step_done), 1);
        chk("clr_idx", int'(step_idx), 1);
        steps(4);
        chk_lv("clr_lv", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
